hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Parametrised successor to the pipeline stall unit. It keeps a registered scoreboard of in-flight register writers, one entry per tracked stage downstream of D. It owns the multiply/divide busy countdown. It raises `stall` for the D stage on data, MDU and ERET/EPC hazards. Sits beside the D/E pipeline register; `stall` freezes PC/F/D and injects a bubble into E.

## Interface
- `DEPTH`, 2: tracked stages after D (entry 0 = E, entry DEPTH-1 = last stage before W); legal 1..6
- `TW`, 3: width of Tnew/Tuse fields
- `MUL_LAT`, 5: MDU busy cycles for mult/multu
- `DIV_LAT`, 10: MDU busy cycles for div/divu; both latencies 1..2^8-1
- `clk` in 1: clock
- `reset` in 1: synchronous, active-low reset
- `flush` in 1: exception/ERET flush; cancels D issue and all entries
- `d_rs`, `d_rt` in 5: D source registers
- `d_tuse_rs`, `d_tuse_rt` in TW: cycles until D consumes rs/rt (value ≥4 = not used)
- `d_we` in 1: D instruction writes a GPR
- `d_wa` in 5: D destination register
- `d_tnew` in TW: Tnew the D instruction will have on entering E
- `d_md_start` in 1: D is mult/multu/div/divu
- `d_md_div` in 1: with `d_md_start`, selects DIV_LAT
- `d_md_use` in 1: D is any MDU instruction (start, mf*, mt*)
- `d_mtc0_epc` in 1: D is mtc0 to CP0 reg 14
- `d_eret` in 1: D is eret
- `md_busy_in` in 1: external MDU busy, used only when SCOREBOARD_MDU_EN is undefined
- `stall` out 1: freeze D this cycle
- `stall_cause` out 3: {eret, md, data}, one-hot or multi-hot, combinational
- `md_busy` out 1: internal MDU countdown nonzero

## Operation
- Entry i = {wv, wa[4:0], tnew[TW-1:0], epc}. Issue = `!stall && !flush`.
- Entry 0 next state:
  - on issue: {d_we && d_wa!=0, d_wa, d_tnew, d_mtc0_epc}
  - otherwise: all-zero bubble.
- Entry i>0 next state: entry i-1 with tnew decremented, saturating at 0.
- flush: every entry becomes all-zero at the edge.
- Data hazard on rs:
  - Find the lowest index i with wv_i && wa_i==d_rs, ignoring d_rs==0.
  - Hazard if d_tuse_rs < tnew_i. Older matching entries are ignored, because the youngest writer is the forwarded source.
  - rt is identical using d_rt and d_tuse_rt.
- MDU, 8-bit `md_cnt`:
  - On issue with d_md_start: load DIV_LAT if d_md_div, else MUL_LAT.
  - Otherwise decrement if nonzero.
  - md_busy = md_cnt!=0.
  - md hazard = d_md_use && md_busy.
  - flush does not clear md_cnt. An issued operation runs to completion.
- ERET hazard: d_eret && any entry has epc=1.
- stall = OR of the three hazards. `stall` does not gate flush.

## Timing
- `stall` and `stall_cause` are combinational from current entries, md_cnt and D inputs. There is no registered output delay.
- Entries and md_cnt update on the rising edge of `clk`.
- Reset (reset==0 at the edge), which overrides flush and issue:
  - all entries zero, md_cnt=0
  - hence stall=0, stall_cause=0, md_busy=0 from the following cycle, provided D inputs are quiet.
- Reset mid-operation discards pending writers and any MDU countdown.
- Simultaneous flush and stall: entry 0 gets a bubble and the others clear. The result is the same as flush alone.
- md issue latency: after issue at edge t, md_busy=1 for cycles t..t+LAT-1 and 0 from t+LAT.

## Configuration
- `SCOREBOARD_MDU_EN` defined:
  - internal md_cnt as above
  - `md_busy_in` ignored.
- `SCOREBOARD_MDU_EN` undefined:
  - md_cnt logic removed, `md_busy` tied 0, MUL_LAT/DIV_LAT unused
  - md hazard = d_md_use && md_busy_in.

## Test plan
- Load-use:
  - Stimulus: issue lw $2 (d_tnew=2); next cycle D addu rs=$2 (tuse_rs=1).
  - Response: stall=1, stall_cause=3'b001 for exactly 1 cycle; 0 the cycle after, with the lw entry at tnew=1.
- Branch after ALU:
  - Stimulus: addu $3 (d_tnew=1), then beq rs=$3 (tuse 0).
  - Response: stall 1 cycle, released when the entry reaches index 1 with tnew=0.
- Nearest-writer:
  - Setup: lw $31 in entry 1 (tnew 1); jal $31 in entry 0 (tnew 0).
  - Stimulus: D jr $31 (tuse 0).
  - Response: stall=0.
- MDU (MUL_LAT=5, macro defined):
  - Stimulus: issue mult, then hold mflo in D.
  - Response: stall_cause=3'b010 for 5 cycles, released on the 6th. With div and DIV_LAT=10, stalls for 10 cycles.
- EPC (DEPTH=2):
  - Stimulus: issue mtc0 $14, then eret in D.
  - Response: stall_cause=3'b100 for 2 cycles, then 0.
- Reset/flush:
  - Reset: with valid entries and md_cnt=7, drive reset=0 for one edge. Response: entries clear, md_busy=0, stall=0.
  - Flush: with lw $2 in entry 0 and D addu $2, assert flush. Response: next cycle stall=0 and entries are empty.

Source files
------------

// File: rtl/hazard_scoreboard.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard
// Brief    : Registered scoreboard of in-flight GPR writers downstream of D.
//            Raises a combinational D-stage stall on data (Tuse/Tnew), MDU
//            busy and ERET-after-mtc0-EPC hazards.
//            Optional macro SCOREBOARD_MDU_EN: when defined, the MDU busy
//            countdown is kept internally; when undefined, the external
//            md_busy_in is used and md_busy is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_scoreboard #(
    parameter int DEPTH   = 2,
    parameter int TW      = 3,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic [4:0]    d_rs,
    input  logic [4:0]    d_rt,
    input  logic [TW-1:0] d_tuse_rs,
    input  logic [TW-1:0] d_tuse_rt,
    input  logic          d_we,
    input  logic [4:0]    d_wa,
    input  logic [TW-1:0] d_tnew,
    input  logic          d_md_start,
    input  logic          d_md_div,
    input  logic          d_md_use,
    input  logic          d_mtc0_epc,
    input  logic          d_eret,
    input  logic          md_busy_in,
    output logic          stall,
    output logic [2:0]    stall_cause,
    output logic          md_busy
);

    localparam logic [TW-1:0] c_tnew_one = {{(TW-1){1'b0}}, 1'b1};
    localparam logic [7:0]    c_mul_lat  = 8'(MUL_LAT);
    localparam logic [7:0]    c_div_lat  = 8'(DIV_LAT);

    // Scoreboard entries: index 0 is the E stage, DEPTH-1 the last before W
    logic [DEPTH-1:0] r_wv;
    logic [DEPTH-1:0] r_epc;
    logic [4:0]       r_wa   [DEPTH];
    logic [TW-1:0]    r_tnew [DEPTH];

    logic w_issue;
    logic w_match_rs;
    logic w_match_rt;
    logic w_haz_data;
    logic w_haz_md;
    logic w_haz_eret;
    logic w_md_busy_eff;

    assign w_issue = !stall && !flush;

    // Entry 0 captures the issuing D instruction (or a bubble); older entries
    // shift down one slot per cycle with Tnew counting toward zero.
    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_wv[i]   <= 1'b0;
                r_wa[i]   <= 5'd0;
                r_tnew[i] <= '0;
                r_epc[i]  <= 1'b0;
            end
        end else begin
            if (w_issue) begin
                r_wv[0]   <= d_we && (|d_wa);
                r_wa[0]   <= d_wa;
                r_tnew[0] <= d_tnew;
                r_epc[0]  <= d_mtc0_epc;
            end else begin
                r_wv[0]   <= 1'b0;
                r_wa[0]   <= 5'd0;
                r_tnew[0] <= '0;
                r_epc[0]  <= 1'b0;
            end
            for (int i = 1; i < DEPTH; i++) begin
                r_wv[i]   <= r_wv[i-1];
                r_wa[i]   <= r_wa[i-1];
                r_tnew[i] <= (|r_tnew[i-1]) ? (r_tnew[i-1] - c_tnew_one) : '0;
                r_epc[i]  <= r_epc[i-1];
            end
        end
    end

    // Youngest matching writer decides the hazard: walk from oldest to
    // youngest so the lowest index overwrites any older match.
    always_comb begin
        w_match_rs = 1'b0;
        w_match_rt = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (r_wv[i] && (r_wa[i] == d_rs)) begin
                w_match_rs = (d_tuse_rs < r_tnew[i]);
            end
            if (r_wv[i] && (r_wa[i] == d_rt)) begin
                w_match_rt = (d_tuse_rt < r_tnew[i]);
            end
        end
    end

    assign w_haz_data = ((|d_rs) && w_match_rs) || ((|d_rt) && w_match_rt);
    assign w_haz_md   = d_md_use && w_md_busy_eff;
    assign w_haz_eret = d_eret && (|r_epc);

    assign stall_cause = {w_haz_eret, w_haz_md, w_haz_data};
    assign stall       = |stall_cause;

`ifdef SCOREBOARD_MDU_EN
    logic [7:0] r_md_cnt;
    logic       w_unused_md_in;

    // MDU countdown: loads on issue of mult/div, survives flush so an issued
    // operation always completes.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_md_cnt <= 8'd0;
        end else if (w_issue && d_md_start) begin
            r_md_cnt <= d_md_div ? c_div_lat : c_mul_lat;
        end else if (|r_md_cnt) begin
            r_md_cnt <= r_md_cnt - 8'd1;
        end
    end

    assign md_busy        = |r_md_cnt;
    assign w_md_busy_eff  = md_busy;
    assign w_unused_md_in = md_busy_in;
`else
    logic w_unused_cfg;

    assign md_busy       = 1'b0;
    assign w_md_busy_eff = md_busy_in;
    assign w_unused_cfg  = ^{d_md_start, d_md_div, c_mul_lat, c_div_lat};
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_hazard_scoreboard
// Brief    : Directed self-checking bench for hazard_scoreboard (default
//            parameters). MDU checks follow whichever SCOREBOARD_MDU_EN build
//            is compiled.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       reset;
    logic       flush;
    logic [4:0] d_rs, d_rt, d_wa;
    logic [2:0] d_tuse_rs, d_tuse_rt, d_tnew;
    logic       d_we, d_md_start, d_md_div, d_md_use, d_mtc0_epc, d_eret;
    logic       md_busy_in;
    logic       stall;
    logic [2:0] stall_cause;
    logic       md_busy;

    int n_checks = 0;
    int n_fail   = 0;
    int n_cyc;

    always #5 clk = ~clk;

    hazard_scoreboard #(
        .DEPTH   (2),
        .TW      (3),
        .MUL_LAT (5),
        .DIV_LAT (10)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .d_rs        (d_rs),
        .d_rt        (d_rt),
        .d_tuse_rs   (d_tuse_rs),
        .d_tuse_rt   (d_tuse_rt),
        .d_we        (d_we),
        .d_wa        (d_wa),
        .d_tnew      (d_tnew),
        .d_md_start  (d_md_start),
        .d_md_div    (d_md_div),
        .d_md_use    (d_md_use),
        .d_mtc0_epc  (d_mtc0_epc),
        .d_eret      (d_eret),
        .md_busy_in  (md_busy_in),
        .stall       (stall),
        .stall_cause (stall_cause),
        .md_busy     (md_busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic quiet();
        d_rs = 5'd0; d_rt = 5'd0; d_tuse_rs = 3'd7; d_tuse_rt = 3'd7;
        d_we = 1'b0; d_wa = 5'd0; d_tnew = 3'd0;
        d_md_start = 1'b0; d_md_div = 1'b0; d_md_use = 1'b0;
        d_mtc0_epc = 1'b0; d_eret = 1'b0; md_busy_in = 1'b0; flush = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Count consecutive cycles showing an MDU-only stall, bounded
    task automatic count_md(output int n);
        n = 0;
        for (int k = 0; k < 30; k++) begin
            #1;
            if (stall_cause != 3'b010) break;
            n++;
            tick();
        end
    endtask

    initial begin
        reset = 1'b0;
        quiet();
        tick(); tick();
        reset = 1'b1;
        #1;
        check_eq("rst_stall", 32'(stall), 0);
        check_eq("rst_cause", 32'(stall_cause), 0);
        check_eq("rst_md_busy", 32'(md_busy), 0);
        tick();

        // Load-use: lw $2 (tnew 2) then addu rs=$2 (tuse 1)
        d_we = 1'b1; d_wa = 5'd2; d_tnew = 3'd2;
        #1 check_eq("lu_issue", 32'(stall), 0);
        tick();
        quiet(); d_rs = 5'd2; d_tuse_rs = 3'd1; d_we = 1'b1; d_wa = 5'd4; d_tnew = 3'd1;
        #1 check_eq("lu_stall", 32'(stall), 1);
        check_eq("lu_cause", 32'(stall_cause), 3'b001);
        tick();
        d_tuse_rs = 3'd0;
        #1 check_eq("lu_probe_tnew1", 32'(stall), 1);
        d_tuse_rs = 3'd1;
        #1 check_eq("lu_release", 32'(stall), 0);
        tick(); quiet(); tick(); tick(); tick();

        // Branch after ALU on rs, then on rt
        d_we = 1'b1; d_wa = 5'd3; d_tnew = 3'd1;
        tick();
        quiet(); d_rs = 5'd3; d_tuse_rs = 3'd0;
        #1 check_eq("br_stall", 32'(stall), 1);
        tick();
        #1 check_eq("br_release", 32'(stall), 0);
        quiet(); tick(); tick();
        d_we = 1'b1; d_wa = 5'd5; d_tnew = 3'd1;
        tick();
        quiet(); d_rt = 5'd5; d_tuse_rt = 3'd0;
        #1 check_eq("br_rt_cause", 32'(stall_cause), 3'b001);
        quiet(); tick(); tick();

        // Writes to $0 never create a hazard
        d_we = 1'b1; d_wa = 5'd0; d_tnew = 3'd2;
        tick();
        quiet(); d_tuse_rs = 3'd0; d_tuse_rt = 3'd0;
        #1 check_eq("r0_no_stall", 32'(stall), 0);
        tick(); tick();

        // Nearest writer: lw $31 older, jal $31 younger with tnew 0
        d_we = 1'b1; d_wa = 5'd31; d_tnew = 3'd2;
        tick();
        quiet(); d_we = 1'b1; d_wa = 5'd31; d_tnew = 3'd0;
        #1 check_eq("nw_jal_issue", 32'(stall), 0);
        tick();
        quiet(); d_rs = 5'd31; d_tuse_rs = 3'd0;
        #1 check_eq("nw_jr", 32'(stall), 0);
        quiet(); tick(); tick(); tick();

`ifdef SCOREBOARD_MDU_EN
        // mult then mflo: 5 stalled cycles
        d_md_start = 1'b1; d_md_use = 1'b1;
        #1 check_eq("md_mult_issue", 32'(stall), 0);
        tick();
        quiet(); d_md_use = 1'b1;
        #1 check_eq("md_busy_set", 32'(md_busy), 1);
        count_md(n_cyc);
        check_eq("md_mul_cycles", 32'(n_cyc), 5);
        check_eq("md_mul_release", 32'(md_busy), 0);
        tick();
        // div then mflo: 10 stalled cycles
        quiet(); d_md_start = 1'b1; d_md_div = 1'b1; d_md_use = 1'b1;
        tick();
        quiet(); d_md_use = 1'b1;
        count_md(n_cyc);
        check_eq("md_div_cycles", 32'(n_cyc), 10);
        // external busy ignored
        quiet(); md_busy_in = 1'b1; d_md_use = 1'b1;
        #1 check_eq("md_in_ignored", 32'(stall), 0);
        // flush keeps the countdown running
        quiet(); d_md_start = 1'b1; d_md_use = 1'b1;
        tick();
        quiet(); flush = 1'b1;
        tick();
        quiet(); d_md_use = 1'b1;
        count_md(n_cyc);
        check_eq("md_flush_keeps", 32'(n_cyc), 4);
        quiet(); tick();
`else
        md_busy_in = 1'b1; d_md_use = 1'b1;
        #1 check_eq("md_ext_cause", 32'(stall_cause), 3'b010);
        d_md_use = 1'b0;
        #1 check_eq("md_ext_nouse", 32'(stall), 0);
        quiet(); d_md_start = 1'b1; d_md_use = 1'b1;
        tick();
        quiet(); d_md_use = 1'b1;
        #1 check_eq("md_tied_low", 32'(md_busy), 0);
        check_eq("md_no_internal", 32'(stall), 0);
        quiet(); tick();
`endif

        // mtc0 EPC then eret: 2 stalled cycles at DEPTH 2
        d_mtc0_epc = 1'b1;
        #1 check_eq("epc_issue", 32'(stall), 0);
        tick();
        quiet(); d_eret = 1'b1;
        #1 check_eq("epc_cause0", 32'(stall_cause), 3'b100);
        tick();
        #1 check_eq("epc_cause1", 32'(stall_cause), 3'b100);
        tick();
        #1 check_eq("epc_release", 32'(stall_cause), 0);
        quiet(); tick();

        // Multi-hot: entry both writes $2 and is an EPC write
        d_we = 1'b1; d_wa = 5'd2; d_tnew = 3'd2; d_mtc0_epc = 1'b1;
        tick();
        quiet(); d_eret = 1'b1; d_rs = 5'd2; d_tuse_rs = 3'd0;
        #1 check_eq("multi_cause", 32'(stall_cause), 3'b101);
        quiet(); tick(); tick(); tick();

        // Reset mid-operation (md_cnt = 7 in the MDU build)
`ifdef SCOREBOARD_MDU_EN
        d_md_start = 1'b1; d_md_div = 1'b1; d_md_use = 1'b1;
        tick();
        quiet(); tick(); tick();
`endif
        d_we = 1'b1; d_wa = 5'd2; d_tnew = 3'd2;
        tick();
        quiet(); d_rs = 5'd2; d_tuse_rs = 3'd1;
        #1 check_eq("rst_pre_stall", 32'(stall), 1);
`ifdef SCOREBOARD_MDU_EN
        check_eq("rst_pre_busy", 32'(md_busy), 1);
`endif
        quiet(); reset = 1'b0; d_we = 1'b1; d_wa = 5'd2; d_tnew = 3'd2;
        tick();
        reset = 1'b1; quiet();
        #1 check_eq("rst_mid_busy", 32'(md_busy), 0);
        check_eq("rst_mid_cause", 32'(stall_cause), 0);
        d_rs = 5'd2; d_tuse_rs = 3'd0; d_md_use = 1'b1;
        #1 check_eq("rst_mid_entries", 32'(stall), 0);
        quiet(); tick();

        // Flush with a pending load-use stall
        d_we = 1'b1; d_wa = 5'd2; d_tnew = 3'd2;
        tick();
        quiet(); d_rs = 5'd2; d_tuse_rs = 3'd1; flush = 1'b1;
        #1 check_eq("fl_stall_during", 32'(stall), 1);
        tick();
        flush = 1'b0;
        #1 check_eq("fl_after", 32'(stall), 0);
        d_tuse_rs = 3'd0;
        #1 check_eq("fl_entries_empty", 32'(stall), 0);
        quiet(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
